// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Bundle of signals between the writeback/decode stages and the
//               register file scoreboard.
//               master : pipeline side. It drives the write, retire, read and
//                        issue requests and receives the read data, stall and
//                        error outputs.
//               slave  : register file side.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int DW   = 16,
  parameter int NREG = 16
);
  localparam int AW = $clog2(NREG);

  // Write port from writeback
  logic          w_on;
  logic [AW-1:0] waddr;
  logic [DW-1:0] datain;
  // Retirement from writeback
  logic          endwrite;
  logic [AW-1:0] endreg;
  // Decode read ports
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          rden_a;
  logic          rden_b;
  // Decode issue
  logic          issue;
  logic [AW-1:0] issue_reg;
  // Results
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          stall;
  logic          err;

  modport master (
    output w_on, waddr, datain, endwrite, endreg,
           raddr_a, raddr_b, rden_a, rden_b, issue, issue_reg,
    input  rdata_a, rdata_b, stall, err
  );

  modport slave (
    input  w_on, waddr, datain, endwrite, endreg,
           raddr_a, raddr_b, rden_a, rden_b, issue, issue_reg,
    output rdata_a, rdata_b, stall, err
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Sixteen-entry register file with two combinational read ports,
//               same-cycle write bypass, and a per-register pending-write
//               counter that stalls decode on RAW and WAW hazards.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - regfile_scoreboard_if.slave. It carries the write,
//                       retire, read and issue inputs and the rdata, stall
//                       and err outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int CW   = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  regfile_scoreboard_if.slave   bus
);
  localparam int          AW     = $clog2(NREG);
  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [CW-1:0]   cnt_q  [NREG];
  logic [CW-1:0]   cnt_d  [NREG];
  logic            err_q;
  logic            err_d;
  logic [NREG-1:0] busy;
  logic            stall;

  // --------------------------------------------------------------------------
  // Busy map. A register whose only pending write is retiring this cycle is
  // free, because the retiring value is already on the bypass path.
  // --------------------------------------------------------------------------
  assign busy[0] = 1'b0;
  for (genvar r = 1; r < NREG; r++) begin : g_busy
    assign busy[r] = (cnt_q[r] != '0) &&
                     !(bus.endwrite && (bus.endreg == AW'(r)) &&
                       (cnt_q[r] == CW'(1)));
  end

  assign stall = (bus.rden_a && busy[bus.raddr_a]) ||
                 (bus.rden_b && busy[bus.raddr_b]) ||
                 (bus.issue  && busy[bus.issue_reg]);

  assign bus.stall = stall;
  assign bus.err   = err_q;

  // --------------------------------------------------------------------------
  // Read ports with same-cycle write bypass. The bypass ignores rden_x.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.rdata_a = regs_q[bus.raddr_a];
    if (bus.raddr_a == '0)
      bus.rdata_a = '0;
    else if (bus.w_on && (bus.waddr == bus.raddr_a))
      bus.rdata_a = bus.datain;

    bus.rdata_b = regs_q[bus.raddr_b];
    if (bus.raddr_b == '0)
      bus.rdata_b = '0;
    else if (bus.w_on && (bus.waddr == bus.raddr_b))
      bus.rdata_b = bus.datain;
  end

  // --------------------------------------------------------------------------
  // Next-state: array write, counters, sticky error
  // --------------------------------------------------------------------------
  always_comb begin
    logic inc;
    logic dec;
    regs_d = regs_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    inc    = 1'b0;
    dec    = 1'b0;

    if (bus.w_on && (bus.waddr != '0))
      regs_d[bus.waddr] = bus.datain;

    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc = bus.issue && !stall && (bus.issue_reg == AW'(r));
      dec = bus.endwrite && (bus.endreg == AW'(r));
      // Simultaneous increment and decrement cancel out.
      if (inc && !dec) begin
        if (cnt_q[r] == C_CNT_MAX) err_d = 1'b1;
        else                       cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed table-driven bench for regfile_scoreboard, plus
//               hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  regfile_scoreboard_if #(.DW(16), .NREG(16)) bus ();

  regfile_scoreboard #(.DW(16), .NREG(16), .CW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w_on; int waddr; int datain;
    int endwrite; int endreg;
    int raddr_a; int rden_a; int raddr_b; int rden_b;
    int issue; int issue_reg;
    int exp_a; int exp_b; int exp_stall; int exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle();
    bus.w_on = 0; bus.waddr = 0; bus.datain = 0;
    bus.endwrite = 0; bus.endreg = 0;
    bus.raddr_a = 0; bus.rden_a = 0; bus.raddr_b = 0; bus.rden_b = 0;
    bus.issue = 0; bus.issue_reg = 0;
  endtask

  task automatic apply(input vec_t v);
    bus.w_on = 1'(v.w_on); bus.waddr = 4'(v.waddr); bus.datain = 16'(v.datain);
    bus.endwrite = 1'(v.endwrite); bus.endreg = 4'(v.endreg);
    bus.raddr_a = 4'(v.raddr_a); bus.rden_a = 1'(v.rden_a);
    bus.raddr_b = 4'(v.raddr_b); bus.rden_b = 1'(v.rden_b);
    bus.issue = 1'(v.issue); bus.issue_reg = 4'(v.issue_reg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    idle();

    //   w  wa  data   ew er  ra ea rb eb  is ir  expA    expB    st er
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 0});
    vecs.push_back('{1, 3, 'hBEEF, 0, 0, 3, 0, 5, 0, 0, 0, 'hBEEF, 'h0000, 0, 0}); // bypass
    vecs.push_back('{0, 0, 'h0000, 0, 0, 3, 1, 0, 0, 0, 0, 'hBEEF, 'h0000, 0, 0}); // array
    vecs.push_back('{1, 0, 'hFFFF, 0, 0, 0, 1, 0, 1, 0, 0, 'h0000, 'h0000, 0, 0}); // r0 write
    vecs.push_back('{1, 5, 'h1111, 0, 0, 5, 0, 3, 0, 0, 0, 'h1111, 'hBEEF, 0, 0});
    vecs.push_back('{0, 0, 'h0000, 0, 0, 3, 1, 0, 0, 1, 7, 'hBEEF, 'h0000, 0, 0}); // issue r7
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 7, 1, 0, 0, 'h0000, 'h0000, 1, 0}); // RAW
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 7, 1, 0, 0, 'h0000, 'h0000, 1, 0});
    vecs.push_back('{0, 0, 'h0000, 0, 0, 7, 0, 7, 0, 0, 0, 'h0000, 'h0000, 0, 0}); // rden mask
    vecs.push_back('{1, 7, 'h00A5, 1, 7, 0, 0, 7, 1, 0, 0, 'h0000, 'h00A5, 0, 0}); // retire r7
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 7, 1, 0, 0, 'h0000, 'h00A5, 0, 0});
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 1, 9, 'h0000, 'h0000, 0, 0}); // issue r9
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 1, 9, 'h0000, 'h0000, 1, 0}); // WAW
    vecs.push_back('{1, 9, 'h0909, 1, 9, 0, 0, 0, 0, 1, 9, 'h0000, 'h0000, 0, 0}); // retire+issue
    vecs.push_back('{0, 0, 'h0000, 0, 0, 9, 1, 0, 0, 0, 0, 'h0909, 'h0000, 1, 0}); // still 1
    vecs.push_back('{1, 9, 'h9999, 1, 9, 9, 1, 0, 0, 0, 0, 'h9999, 'h0000, 0, 0}); // retire r9
    vecs.push_back('{0, 0, 'h0000, 0, 0, 9, 1, 0, 0, 0, 0, 'h9999, 'h0000, 0, 0});
    vecs.push_back('{0, 0, 'h0000, 1, 4, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 0}); // underflow
    vecs.push_back('{0, 0, 'h0000, 0, 0, 4, 1, 0, 0, 0, 0, 'h0000, 'h0000, 0, 1}); // cnt4 held 0
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 'h0000, 'h0000, 0, 1}); // issue r0
    vecs.push_back('{0, 0, 'h0000, 0, 0, 0, 1, 0, 1, 0, 0, 'h0000, 'h0000, 0, 1}); // r0 not busy
    vecs.push_back('{0, 0, 'h0000, 0, 0, 3, 1, 5, 1, 0, 0, 'hBEEF, 'h1111, 0, 1}); // err sticky

    // Reset state
    #12;
    check("rst_rdata_a", 32'(bus.rdata_a), 32'h0);
    check("rst_stall",   32'(bus.stall),   32'h0);
    check("rst_err",     32'(bus.err),     32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #2;
      check($sformatf("v%0d_rdata_a", i), 32'(bus.rdata_a), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_rdata_b", i), 32'(bus.rdata_b), 32'(vecs[i].exp_b));
      check($sformatf("v%0d_stall", i),   32'(bus.stall),   32'(vecs[i].exp_stall));
      check($sformatf("v%0d_err", i),     32'(bus.err),     32'(vecs[i].exp_err));
      @(posedge clk); #1;
    end

    // Reset mid-operation: reg5 written, reg7 pending, ERR set
    idle();
    bus.w_on = 1; bus.waddr = 5; bus.datain = 16'h1234;
    bus.issue = 1; bus.issue_reg = 7;
    @(posedge clk); #1;
    idle();
    bus.raddr_a = 5; bus.rden_b = 1; bus.raddr_b = 7;
    #1;
    check("pre_rst_rdata_a", 32'(bus.rdata_a), 32'h1234);
    check("pre_rst_stall",   32'(bus.stall),   32'h1);
    check("pre_rst_err",     32'(bus.err),     32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata_a", 32'(bus.rdata_a), 32'h0);
    check("mid_rst_stall",   32'(bus.stall),   32'h0);
    check("mid_rst_err",     32'(bus.err),     32'h0);
    // Bypass still live while held in reset
    bus.w_on = 1; bus.waddr = 5; bus.datain = 16'h5555;
    #1;
    check("rst_bypass", 32'(bus.rdata_a), 32'h5555);
    bus.w_on = 0;
    @(posedge clk); #1;
    check("rst_held_rdata_a", 32'(bus.rdata_a), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rdata_a", 32'(bus.rdata_a), 32'h0);
    check("post_rst_stall",   32'(bus.stall),   32'h0);
    check("post_rst_err",     32'(bus.err),     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register file and write-tracking scoreboard at the receiving end of the writeback stage's register-write interface. Holds the sixteen 16-bit general registers and accepts one write per cycle from writeback. Serves two combinational read ports to the decode stage, with same-cycle write bypass. Counts in-flight writes per register and raises STALL when decode would read or issue against a register that still has a pending write.

## Interface
- DW, 16, register data width
- NREG, 16, number of registers; register address width is log2(NREG) = 4
- CW, 2, width of per-register pending-write counter (max 3 in flight)

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- W_ON  in  1  write enable from writeback
- WADDR  in  4  write register index
- DATAIN  in  16  write data (writeback DATA_OUT)
- ENDWRITE  in  1  writeback retiring an instruction with a register destination
- ENDREG  in  4  destination register being retired
- RADDR_A, RADDR_B  in  4 each  decode read indices
- RDEN_A, RDEN_B  in  1 each  decode actually uses that operand
- ISSUE  in  1  decode issues an instruction that will write ISSUE_REG
- ISSUE_REG  in  4  destination of issuing instruction
- RDATA_A, RDATA_B  out  16 each  read data, combinational
- STALL  out  1  decode must hold, combinational
- ERR  out  1  sticky protocol error flag, registered

## Operation
- Register 0 reads as 0x0000 always; writes to it are discarded. ISSUE/ENDWRITE with register 0 are ignored by the scoreboard.
- Write: at posedge CLK with W_ON=1 and WADDR!=0, reg[WADDR] <= DATAIN.
- Read: RDATA_x = 0 if RADDR_x==0; else DATAIN if W_ON && WADDR==RADDR_x; else reg[RADDR_x]. Bypass is independent of RDEN_x.
- Scoreboard: one CW-bit counter cnt[r] per register r (1..15), updated each posedge.
  - Increment condition: ISSUE && !STALL && ISSUE_REG==r.
  - Decrement condition: ENDWRITE && ENDREG==r.
  - Both in the same cycle leave cnt[r] unchanged.
  - Increment at cnt==3: counter holds at 3, ERR<=1.
  - Decrement at cnt==0: counter holds at 0, ERR<=1.
- Effective busy: busy[r] = cnt[r]!=0, except when ENDWRITE && ENDREG==r && cnt[r]==1 (the retiring value is on the bypass path).
- STALL = (RDEN_A && busy[RADDR_A]) || (RDEN_B && busy[RADDR_B]) || (ISSUE && busy[ISSUE_REG]).
  - The ISSUE term enforces in-order WAW; the counter therefore normally stays at or below 1. CW=2 exists only to absorb protocol slips.
  - Register 0 is never busy.
- ERR clears only on reset.

## Timing
- Reset (RST_N low, asynchronous): all registers 0x0000, all cnt 0, ERR 0.
  - Combinational outputs during reset follow the reset state: RDATA reads 0 unless the bypass hits, STALL reads 0.
  - Release is synchronous to the next CLK edge.
- Reset mid-operation discards all pending-write state. Upstream stages are reset together, so no late ENDWRITE is expected.
- Write latency: data is visible on the read port in the same cycle via bypass, and from the array from the next cycle.
- Scoreboard latency: an issue at edge N makes the register busy for cycles after N. Retirement frees the register in the same cycle ENDWRITE is presented.
- In normal use, W_ON and ENDWRITE assert together with WADDR==ENDREG. They are nonetheless handled independently.
- No multicycle paths. The longest combinational path is RADDR to RDATA/STALL.

## Test plan
- Reset: write reg5=0x1234, then pulse RST_N low between edges -> RDATA_A with RADDR_A=5 reads 0x0000 immediately; STALL=0; ERR=0.
- Write/read and R0: W_ON, WADDR=3, DATAIN=0xBEEF -> RDATA_A(3)=0xBEEF in the same cycle (bypass) and after the edge. W_ON, WADDR=0, DATAIN=0xFFFF -> RDATA(0)=0x0000.
- RAW stall: ISSUE reg7, then next cycle RDEN_B=1, RADDR_B=7 -> STALL=1. This persists until the cycle with ENDWRITE/W_ON reg7, DATAIN=0x00A5, in which STALL=0 and RDATA_B=0x00A5.
- RDEN masking: reg7 busy, RADDR_A=7 with RDEN_A=0 -> STALL=0.
- WAW stall: ISSUE reg9 accepted; next cycle ISSUE reg9 -> STALL=1 and cnt[9] stays 1. On the ENDWRITE reg9 cycle the second ISSUE is accepted, cnt[9] remains 1, and STALL=0.
- Errors: ENDWRITE reg4 with cnt[4]=0 -> ERR=1 after the edge, cnt[4]=0. ERR stays 1 until reset.
